// File: rtl/instruction_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: opcodes, funct fields,
// inst_flags bit positions and the fixed SYSTEM words.
package rv32i_enc_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD    = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_SLTU   = 3'b011;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_SR     = 3'b101;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3_BLT    = 3'b100;
    localparam logic [2:0] F3_BGE    = 3'b101;
    localparam logic [2:0] F3_BLTU   = 3'b110;
    localparam logic [2:0] F3_BGEU   = 3'b111;
    localparam logic [2:0] F3_LB     = 3'b000;
    localparam logic [2:0] F3_LH     = 3'b001;
    localparam logic [2:0] F3_LW     = 3'b010;
    localparam logic [2:0] F3_LBU    = 3'b100;
    localparam logic [2:0] F3_LHU    = 3'b101;
    localparam logic [2:0] F3_SB     = 3'b000;
    localparam logic [2:0] F3_SH     = 3'b001;
    localparam logic [2:0] F3_SW     = 3'b010;
    localparam logic [2:0] F3_JALR   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int unsigned IDX_BNE    = 47;
    localparam int unsigned IDX_BLTU   = 46;
    localparam int unsigned IDX_BLT    = 45;
    localparam int unsigned IDX_BGEU   = 44;
    localparam int unsigned IDX_BGE    = 43;
    localparam int unsigned IDX_BEQ    = 42;
    localparam int unsigned IDX_ADDI   = 41;
    localparam int unsigned IDX_SLTI   = 40;
    localparam int unsigned IDX_SLTIU  = 39;
    localparam int unsigned IDX_XORI   = 38;
    localparam int unsigned IDX_ORI    = 37;
    localparam int unsigned IDX_ANDI   = 36;
    localparam int unsigned IDX_SLLI   = 35;
    localparam int unsigned IDX_SRLI   = 34;
    localparam int unsigned IDX_SRAI   = 33;
    localparam int unsigned IDX_ADD    = 32;
    localparam int unsigned IDX_SUB    = 31;
    localparam int unsigned IDX_SLL    = 30;
    localparam int unsigned IDX_SLT    = 29;
    localparam int unsigned IDX_SLTU   = 28;
    localparam int unsigned IDX_XOR    = 27;
    localparam int unsigned IDX_OR     = 26;
    localparam int unsigned IDX_AND    = 25;
    localparam int unsigned IDX_LB     = 24;
    localparam int unsigned IDX_LH     = 23;
    localparam int unsigned IDX_LW     = 22;
    localparam int unsigned IDX_LBU    = 21;
    localparam int unsigned IDX_LHU    = 20;
    localparam int unsigned IDX_SB     = 19;
    localparam int unsigned IDX_SH     = 18;
    localparam int unsigned IDX_SW     = 17;
    localparam int unsigned IDX_CSRRW  = 16;
    localparam int unsigned IDX_CSRRS  = 15;
    localparam int unsigned IDX_CSRRC  = 14;
    localparam int unsigned IDX_CSRRWI = 13;
    localparam int unsigned IDX_CSRRSI = 12;
    localparam int unsigned IDX_CSRRCI = 11;
    localparam int unsigned IDX_SRET   = 10;
    localparam int unsigned IDX_WFI    = 9;
    localparam int unsigned IDX_MRET   = 8;
    localparam int unsigned IDX_ECALL  = 7;
    localparam int unsigned IDX_EBREAK = 6;
    localparam int unsigned IDX_JALR   = 5;
    localparam int unsigned IDX_JAL    = 4;
    localparam int unsigned IDX_AUIPC  = 3;
    localparam int unsigned IDX_LUI    = 2;
    localparam int unsigned IDX_SRA    = 1;
    localparam int unsigned IDX_SRL    = 0;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;
    localparam logic [31:0] WORD_SRET   = 32'h1020_0073;
    localparam logic [31:0] WORD_MRET   = 32'h3020_0073;
    localparam logic [31:0] WORD_WFI    = 32'h1050_0073;

    typedef enum logic [3:0] {
        FmtNone,
        FmtR,
        FmtI,
        FmtShift,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtFixed
    } enc_fmt_e;

    function automatic logic is_one_hot48(input logic [47:0] v);
        return (v != '0) && ((v & (v - 48'd1)) == '0);
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Request/response bundle between a stimulus source (master) and the encoder (slave).
interface instruction_encoder_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [47:0]      inst_flags;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      instruction_code;
    logic             invalid_instruction;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, inst_flags, rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instruction_code, invalid_instruction, enc_count, err_count
    );

    modport slave (
        input  in_valid, inst_flags, rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instruction_code, invalid_instruction, enc_count, err_count
    );

endinterface

// File: rtl/instruction_encoder_fifo.sv
// Two-entry output buffer for encoded words; head register is always the oldest entry.
module inst_enc_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam logic [1:0] FullCount = 2'(DEPTH);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == 2'd0);
    assign head  = head_q;

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (empty) begin
                    head_d = wdata;
                end else begin
                    tail_d = wdata;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Push and pop together only happen at occupancy 1: new word goes straight to head.
            2'b11: head_d = wdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I encoder: one-hot select plus fields in, 32-bit instruction word out
// through a 2-entry buffer; malformed selects are dropped and counted.
module instruction_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    instruction_encoder_if.slave bus
);

    logic [47:0]      f;
    logic             flags_ok;
    logic             accept;
    logic             push;
    logic             reject;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      fifo_head;
    logic [31:0]      word;
    enc_fmt_e         fmt;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [31:0]      fixed_word;
    logic             invalid_q, invalid_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    assign f        = bus.inst_flags;
    assign flags_ok = is_one_hot48(f);
    assign accept   = bus.in_valid && bus.in_ready;
    assign push     = accept && flags_ok;
    assign reject   = accept && !flags_ok;
    assign pop      = bus.out_valid && bus.out_ready;

    assign bus.in_ready            = !fifo_full;
    assign bus.out_valid           = !fifo_empty;
    assign bus.instruction_code    = fifo_head;
    assign bus.invalid_instruction = invalid_q;
    assign bus.enc_count           = enc_count_q;
    assign bus.err_count           = err_count_q;

    // Select is one-hot when valid, so at most one of these fires.
    always_comb begin
        fmt        = FmtNone;
        opc        = '0;
        f3         = '0;
        f7         = F7_BASE;
        fixed_word = '0;
        if (f[IDX_ADD])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_ADD;             end
        if (f[IDX_SUB])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_ADD; f7 = F7_ALT; end
        if (f[IDX_SLL])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_SLL;             end
        if (f[IDX_SLT])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_SLT;             end
        if (f[IDX_SLTU])   begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_SLTU;            end
        if (f[IDX_XOR])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_XOR;             end
        if (f[IDX_SRL])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_SR;              end
        if (f[IDX_SRA])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_SR;  f7 = F7_ALT; end
        if (f[IDX_OR])     begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_OR;              end
        if (f[IDX_AND])    begin fmt = FmtR;     opc = OPC_OP;     f3 = F3_AND;             end
        if (f[IDX_ADDI])   begin fmt = FmtI;     opc = OPC_OPIMM;  f3 = F3_ADD;             end
        if (f[IDX_SLTI])   begin fmt = FmtI;     opc = OPC_OPIMM;  f3 = F3_SLT;             end
        if (f[IDX_SLTIU])  begin fmt = FmtI;     opc = OPC_OPIMM;  f3 = F3_SLTU;            end
        if (f[IDX_XORI])   begin fmt = FmtI;     opc = OPC_OPIMM;  f3 = F3_XOR;             end
        if (f[IDX_ORI])    begin fmt = FmtI;     opc = OPC_OPIMM;  f3 = F3_OR;              end
        if (f[IDX_ANDI])   begin fmt = FmtI;     opc = OPC_OPIMM;  f3 = F3_AND;             end
        if (f[IDX_SLLI])   begin fmt = FmtShift; opc = OPC_OPIMM;  f3 = F3_SLL;             end
        if (f[IDX_SRLI])   begin fmt = FmtShift; opc = OPC_OPIMM;  f3 = F3_SR;              end
        if (f[IDX_SRAI])   begin fmt = FmtShift; opc = OPC_OPIMM;  f3 = F3_SR;  f7 = F7_ALT; end
        if (f[IDX_LB])     begin fmt = FmtI;     opc = OPC_LOAD;   f3 = F3_LB;              end
        if (f[IDX_LH])     begin fmt = FmtI;     opc = OPC_LOAD;   f3 = F3_LH;              end
        if (f[IDX_LW])     begin fmt = FmtI;     opc = OPC_LOAD;   f3 = F3_LW;              end
        if (f[IDX_LBU])    begin fmt = FmtI;     opc = OPC_LOAD;   f3 = F3_LBU;             end
        if (f[IDX_LHU])    begin fmt = FmtI;     opc = OPC_LOAD;   f3 = F3_LHU;             end
        if (f[IDX_SB])     begin fmt = FmtS;     opc = OPC_STORE;  f3 = F3_SB;              end
        if (f[IDX_SH])     begin fmt = FmtS;     opc = OPC_STORE;  f3 = F3_SH;              end
        if (f[IDX_SW])     begin fmt = FmtS;     opc = OPC_STORE;  f3 = F3_SW;              end
        if (f[IDX_BEQ])    begin fmt = FmtB;     opc = OPC_BRANCH; f3 = F3_BEQ;             end
        if (f[IDX_BNE])    begin fmt = FmtB;     opc = OPC_BRANCH; f3 = F3_BNE;             end
        if (f[IDX_BLT])    begin fmt = FmtB;     opc = OPC_BRANCH; f3 = F3_BLT;             end
        if (f[IDX_BGE])    begin fmt = FmtB;     opc = OPC_BRANCH; f3 = F3_BGE;             end
        if (f[IDX_BLTU])   begin fmt = FmtB;     opc = OPC_BRANCH; f3 = F3_BLTU;            end
        if (f[IDX_BGEU])   begin fmt = FmtB;     opc = OPC_BRANCH; f3 = F3_BGEU;            end
        if (f[IDX_LUI])    begin fmt = FmtU;     opc = OPC_LUI;                             end
        if (f[IDX_AUIPC])  begin fmt = FmtU;     opc = OPC_AUIPC;                           end
        if (f[IDX_JAL])    begin fmt = FmtJ;     opc = OPC_JAL;                             end
        if (f[IDX_JALR])   begin fmt = FmtI;     opc = OPC_JALR;   f3 = F3_JALR;            end
        // CSR forms share the I layout: CSR address in the immediate slot, zimm in rs1.
        if (f[IDX_CSRRW])  begin fmt = FmtI;     opc = OPC_SYSTEM; f3 = F3_CSRRW;           end
        if (f[IDX_CSRRS])  begin fmt = FmtI;     opc = OPC_SYSTEM; f3 = F3_CSRRS;           end
        if (f[IDX_CSRRC])  begin fmt = FmtI;     opc = OPC_SYSTEM; f3 = F3_CSRRC;           end
        if (f[IDX_CSRRWI]) begin fmt = FmtI;     opc = OPC_SYSTEM; f3 = F3_CSRRWI;          end
        if (f[IDX_CSRRSI]) begin fmt = FmtI;     opc = OPC_SYSTEM; f3 = F3_CSRRSI;          end
        if (f[IDX_CSRRCI]) begin fmt = FmtI;     opc = OPC_SYSTEM; f3 = F3_CSRRCI;          end
        if (f[IDX_ECALL])  begin fmt = FmtFixed; fixed_word = WORD_ECALL;                   end
        if (f[IDX_EBREAK]) begin fmt = FmtFixed; fixed_word = WORD_EBREAK;                  end
        if (f[IDX_SRET])   begin fmt = FmtFixed; fixed_word = WORD_SRET;                    end
        if (f[IDX_MRET])   begin fmt = FmtFixed; fixed_word = WORD_MRET;                    end
        if (f[IDX_WFI])    begin fmt = FmtFixed; fixed_word = WORD_WFI;                     end
    end

    always_comb begin
        word = '0;
        case (fmt)
            FmtR:     word = {f7, bus.rs2, bus.rs1, f3, bus.rd, opc};
            FmtI:     word = {bus.imm[11:0], bus.rs1, f3, bus.rd, opc};
            FmtShift: word = {f7, bus.imm[4:0], bus.rs1, f3, bus.rd, opc};
            FmtS:     word = {bus.imm[11:5], bus.rs2, bus.rs1, f3, bus.imm[4:0], opc};
            FmtB:     word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, f3,
                              bus.imm[4:1], bus.imm[11], opc};
            FmtU:     word = {bus.imm[31:12], bus.rd, opc};
            FmtJ:     word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                              bus.rd, opc};
            FmtFixed: word = fixed_word;
            default:  word = '0;
        endcase
    end

    inst_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (word),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        invalid_d   = reject;
        enc_count_d = enc_count_q + CNT_W'(push);
        err_count_d = err_count_q + CNT_W'(reject);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_q   <= 1'b0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            invalid_q   <= invalid_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: vector table plus handshake corner sequences.
module tb_instruction_encoder;

    typedef struct {
        int          idx;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    int   exp_enc;
    vec_t vecs[20];
    vec_t v_ecall;

    instruction_encoder_if #(.CNT_W(16)) bus ();

    instruction_encoder #(
        .DEPTH (2),
        .CNT_W (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int idx, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [31:0] exp, input string name);
        vec_t v;
        v.idx = idx; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
        v.name = name;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.inst_flags = 48'd1 << v.idx;
        bus.rd         = v.rd;
        bus.rs1        = v.rs1;
        bus.rs2        = v.rs2;
        bus.imm        = v.imm;
    endtask

    task automatic apply_vec(input int i);
        drive(vecs[i]);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        exp_enc++;
        check(vecs[i].name, bus.instruction_code, vecs[i].exp);
        check({vecs[i].name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({vecs[i].name, "_enc_count"}, 32'(bus.enc_count), 32'(16'(exp_enc)));
        step();
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        exp_enc  = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.inst_flags = '0;
        bus.rd         = '0;
        bus.rs1        = '0;
        bus.rs2        = '0;
        bus.imm        = '0;

        vecs[0]  = mk(41, 5'd1,  5'd0, 5'd0, 32'd5,        32'h0050_0093, "addi");
        vecs[1]  = mk(32, 5'd3,  5'd1, 5'd2, 32'hFFFF_FFFF, 32'h0020_81B3, "add");
        vecs[2]  = mk(31, 5'd3,  5'd1, 5'd2, 32'd0,        32'h4020_81B3, "sub");
        vecs[3]  = mk(42, 5'd31, 5'd1, 5'd2, 32'd8,        32'h0020_8463, "beq");
        vecs[4]  = mk(17, 5'd5,  5'd1, 5'd2, 32'd4,        32'h0020_A223, "sw");
        vecs[5]  = mk(2,  5'd5,  5'd7, 5'd9, 32'h1234_5000, 32'h1234_52B7, "lui");
        vecs[6]  = mk(33, 5'd1,  5'd2, 5'd0, 32'd3,        32'h4031_5093, "srai");
        vecs[7]  = mk(22, 5'd5,  5'd6, 5'd0, 32'hFFFF_FFFC, 32'hFFC3_2283, "lw");
        vecs[8]  = mk(4,  5'd1,  5'd3, 5'd4, 32'h0000_0800, 32'h0010_00EF, "jal");
        vecs[9]  = mk(16, 5'd1,  5'd2, 5'd0, 32'h0000_0300, 32'h3001_10F3, "csrrw");
        vecs[10] = mk(12, 5'd3,  5'd5, 5'd0, 32'h0000_0341, 32'h3412_E1F3, "csrrsi");
        vecs[11] = mk(8,  5'd7,  5'd9, 5'd3, 32'hFFFF_FFFF, 32'h3020_0073, "mret");
        vecs[12] = mk(3,  5'd2,  5'd0, 5'd0, 32'hFFFF_F123, 32'hFFFF_F117, "auipc");
        vecs[13] = mk(47, 5'd0,  5'd3, 5'd4, 32'hFFFF_FFFE, 32'hFE41_9FE3, "bne");
        vecs[14] = mk(1,  5'd1,  5'd2, 5'd3, 32'd0,        32'h4031_50B3, "sra");
        vecs[15] = mk(18, 5'd0,  5'd2, 5'd3, 32'h0000_07FF, 32'h7E31_1FA3, "sh");
        vecs[16] = mk(6,  5'd4,  5'd4, 5'd4, 32'h1234_5678, 32'h0010_0073, "ebreak");
        vecs[17] = mk(9,  5'd0,  5'd0, 5'd0, 32'd0,        32'h1050_0073, "wfi");
        vecs[18] = mk(39, 5'd4,  5'd5, 5'd7, 32'h0000_0800, 32'h8002_B213, "sltiu");
        vecs[19] = mk(0,  5'd1,  5'd2, 5'd3, 32'd0,        32'h0031_50B3, "srl");
        v_ecall  = mk(7,  5'd9,  5'd9, 5'd9, 32'hFFFF_FFFF, 32'h0000_0073, "ecall");

        repeat (2) step();
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_invalid", 32'(bus.invalid_instruction), 32'd0);
        check("rst_code", bus.instruction_code, 32'd0);
        check("rst_enc_count", 32'(bus.enc_count), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);

        for (int i = 0; i < 20; i++) begin
            apply_vec(i);
            check("drained", 32'(bus.out_valid), 32'd0);
        end

        // Back-to-back add then sub with the consumer always ready.
        drive(vecs[1]);
        bus.in_valid = 1'b1;
        step();
        exp_enc++;
        check("b2b_first", bus.instruction_code, vecs[1].exp);
        drive(vecs[2]);
        step();
        exp_enc++;
        bus.in_valid = 1'b0;
        check("b2b_second", bus.instruction_code, vecs[2].exp);
        check("b2b_valid", 32'(bus.out_valid), 32'd1);
        step();
        check("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: third word must stall until a slot frees; no same-cycle bypass.
        bus.out_ready = 1'b0;
        drive(vecs[3]);
        bus.in_valid = 1'b1;
        step();
        exp_enc++;
        check("bp_ready_occ1", 32'(bus.in_ready), 32'd1);
        drive(vecs[4]);
        step();
        exp_enc++;
        check("bp_ready_occ2", 32'(bus.in_ready), 32'd0);
        check("bp_head_1", bus.instruction_code, vecs[3].exp);
        drive(vecs[5]);
        step();
        check("bp_stalled_ready", 32'(bus.in_ready), 32'd0);
        check("bp_head_2", bus.instruction_code, vecs[3].exp);
        check("bp_valid_held", 32'(bus.out_valid), 32'd1);
        check("bp_enc_stalled", 32'(bus.enc_count), 32'(16'(exp_enc)));
        bus.out_ready = 1'b1;
        step();
        check("bp_pop_1", bus.instruction_code, vecs[4].exp);
        check("bp_no_bypass", 32'(bus.enc_count), 32'(16'(exp_enc)));
        check("bp_ready_again", 32'(bus.in_ready), 32'd1);
        step();
        exp_enc++;
        bus.in_valid = 1'b0;
        check("bp_pop_2", bus.instruction_code, vecs[5].exp);
        check("bp_enc_final", 32'(bus.enc_count), 32'(16'(exp_enc)));
        step();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Rejected selects: zero bits, then two bits.
        bus.inst_flags = '0;
        bus.in_valid   = 1'b1;
        step();
        check("inv0_pulse", 32'(bus.invalid_instruction), 32'd1);
        check("inv0_err", 32'(bus.err_count), 32'd1);
        check("inv0_no_word", 32'(bus.out_valid), 32'd0);
        bus.inst_flags = (48'd1 << 41) | (48'd1 << 32);
        step();
        bus.in_valid = 1'b0;
        check("inv2_pulse", 32'(bus.invalid_instruction), 32'd1);
        check("inv2_err", 32'(bus.err_count), 32'd2);
        check("inv2_no_word", 32'(bus.out_valid), 32'd0);
        check("inv2_enc", 32'(bus.enc_count), 32'(16'(exp_enc)));
        step();
        check("inv_pulse_end", 32'(bus.invalid_instruction), 32'd0);
        drive(v_ecall);
        bus.in_valid = 1'b1;
        step();
        exp_enc++;
        bus.in_valid = 1'b0;
        check("ecall", bus.instruction_code, v_ecall.exp);
        check("ecall_no_err", 32'(bus.invalid_instruction), 32'd0);
        step();

        // Reset with two words buffered discards them.
        bus.out_ready = 1'b0;
        drive(vecs[0]);
        bus.in_valid = 1'b1;
        step();
        drive(vecs[1]);
        step();
        bus.in_valid = 1'b0;
        check("pre_rst_full", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_enc = 0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_enc", 32'(bus.enc_count), 32'd0);
        check("mid_rst_err", 32'(bus.err_count), 32'd0);
        check("mid_rst_code", bus.instruction_code, 32'd0);
        bus.out_ready = 1'b1;
        apply_vec(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
